// File: rtl/mem_burst_ui.sv
// mem_burst_ui: burst request adapter onto the DDR3 MIG native user interface.
// Optional watchdog enabled by defining MEM_BURST_TIMEOUT_EN.
module mem_burst_ui #(
  parameter int MEM_DATA_BITS  = 64,
  parameter int ADDR_BITS      = 25,
  parameter int APP_ADDR_BITS  = 28,
  parameter int ADDR_LSB       = 3,
  parameter int BURST_BITS     = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       mem_clk,
  input  logic                       rst,
  input  logic                       init_calib_complete,
  input  logic                       rd_burst_req,
  input  logic                       wr_burst_req,
  input  logic [BURST_BITS-1:0]      rd_burst_len,
  input  logic [BURST_BITS-1:0]      wr_burst_len,
  input  logic [ADDR_BITS-1:0]       rd_burst_addr,
  input  logic [ADDR_BITS-1:0]       wr_burst_addr,
  output logic                       rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0]   rd_burst_data,
  output logic                       wr_burst_data_req,
  input  logic [MEM_DATA_BITS-1:0]   wr_burst_data,
  output logic                       rd_burst_finish,
  output logic                       wr_burst_finish,
  output logic [APP_ADDR_BITS-1:0]   app_addr,
  output logic [2:0]                 app_cmd,
  output logic                       app_en,
  input  logic                       app_rdy,
  output logic [MEM_DATA_BITS-1:0]   app_wdf_data,
  output logic                       app_wdf_wren,
  output logic                       app_wdf_end,
  output logic [MEM_DATA_BITS/8-1:0] app_wdf_mask,
  input  logic                       app_wdf_rdy,
  input  logic [MEM_DATA_BITS-1:0]   app_rd_data,
  input  logic                       app_rd_data_valid,
  output logic                       timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic                     is_rd;
  logic [ADDR_BITS-1:0]     base;
  logic [BURST_BITS-1:0]    len;
  logic [BURST_BITS-1:0]    req_cnt;
  logic [BURST_BITS-1:0]    data_cnt;
  logic [BURST_BITS-1:0]    cmd_cnt;
  logic [BURST_BITS-1:0]    ret_cnt;
  logic [MEM_DATA_BITS-1:0] wbuf [2];
  logic                     wp;
  logic                     rp;
  logic                     req_q;
  logic [1:0]               occ;
  logic                     acc_rd;
  logic                     acc_wr;
  logic                     push;
  logic                     pop;
  logic                     cmd_fire;
  logic                     rd_ret;
  logic                     wd_expire;
  logic [ADDR_BITS-1:0]     beat_addr;

  assign acc_rd = (state == IDLE) && init_calib_complete
               && rd_burst_req;
  assign acc_wr = (state == IDLE) && init_calib_complete
               && !rd_burst_req && wr_burst_req;

  // req_q is a beat already requested but not yet captured
  assign wr_burst_data_req = (state == WRITE) && (req_cnt < len)
                          && ((occ + 2'(req_q)) < 2'd2);

  assign push = req_q;
  assign pop  = app_wdf_wren && app_wdf_rdy;

  assign app_wdf_wren = (state == WRITE) && (occ != 2'd0);
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_data = wbuf[rp];
  assign app_wdf_mask = '0;

  assign app_en = ((state == WRITE) && (cmd_cnt < data_cnt))
               || ((state == READ) && (cmd_cnt < len));
  assign app_cmd  = (state == READ) ? 3'b001 : 3'b000;
  assign cmd_fire = app_en && app_rdy;
  assign rd_ret   = (state == READ) && app_rd_data_valid;

  assign beat_addr = base + ADDR_BITS'(cmd_cnt);
  assign app_addr  = APP_ADDR_BITS'(beat_addr) << ADDR_LSB;

  assign rd_burst_finish = (state == DONE) && is_rd;
  assign wr_burst_finish = (state == DONE) && !is_rd;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (acc_rd)
          nxt = (rd_burst_len == '0) ? DONE : READ;
        else if (acc_wr)
          nxt = (wr_burst_len == '0) ? DONE : WRITE;
      end
      WRITE: begin
        if ((cmd_cnt == len && data_cnt == len) || wd_expire)
          nxt = DONE;
      end
      READ: begin
        if (ret_cnt == len || wd_expire)
          nxt = DONE;
      end
      DONE: nxt = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      is_rd               <= 1'b0;
      base                <= '0;
      len                 <= '0;
      req_cnt             <= '0;
      data_cnt            <= '0;
      cmd_cnt             <= '0;
      ret_cnt             <= '0;
      wbuf[0]             <= '0;
      wbuf[1]             <= '0;
      wp                  <= 1'b0;
      rp                  <= 1'b0;
      req_q               <= 1'b0;
      occ                 <= 2'd0;
      rd_burst_data_valid <= 1'b0;
      rd_burst_data       <= '0;
    end else begin
      state               <= nxt;
      req_q               <= wr_burst_data_req;
      rd_burst_data_valid <= rd_ret;
      if (rd_ret)
        rd_burst_data <= app_rd_data;
      if (acc_rd || acc_wr) begin
        is_rd    <= acc_rd;
        base     <= acc_rd ? rd_burst_addr : wr_burst_addr;
        len      <= acc_rd ? rd_burst_len : wr_burst_len;
        req_cnt  <= '0;
        data_cnt <= '0;
        cmd_cnt  <= '0;
        ret_cnt  <= '0;
        wp       <= 1'b0;
        rp       <= 1'b0;
        occ      <= 2'd0;
      end else begin
        if (wr_burst_data_req)
          req_cnt <= req_cnt + BURST_BITS'(1);
        if (push) begin
          wbuf[wp] <= wr_burst_data;
          wp       <= ~wp;
        end
        if (pop) begin
          rp       <= ~rp;
          data_cnt <= data_cnt + BURST_BITS'(1);
        end
        occ <= occ + 2'(push) - 2'(pop);
        if (cmd_fire)
          cmd_cnt <= cmd_cnt + BURST_BITS'(1);
        if (rd_ret && ret_cnt != len)
          ret_cnt <= ret_cnt + BURST_BITS'(1);
      end
    end
  end

`ifdef MEM_BURST_TIMEOUT_EN
  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_BITS-1:0] wd_cnt;
  logic               busy;
  logic               progress;

  assign busy      = (state == WRITE) || (state == READ);
  assign progress  = cmd_fire || pop || rd_ret;
  assign wd_expire = busy && !progress
                  && (wd_cnt == WD_BITS'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (!busy || progress)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + WD_BITS'(1);
      if (wd_expire)
        timeout_err <= 1'b1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
